// File: rtl/mac_accumulator_if.sv
`default_nettype none
// =============================================================================
// mac_accumulator_if : operand-beat and run-result handshake bundle
// Rev 1.0
// =============================================================================
interface mac_accumulator_if #(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 24
);
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic [PROD_W-1:0] product;
  logic [ACC_W-1:0]  out_data;
  logic              out_ovf;
  logic              out_valid;
  logic              out_ready;
  logic              busy;

  modport master (
    output in_valid, in_last, product, out_ready,
    input  in_ready, out_data, out_ovf, out_valid, busy
  );

  modport slave (
    input  in_valid, in_last, product, out_ready,
    output in_ready, out_data, out_ovf, out_valid, busy
  );
endinterface
`default_nettype wire

// File: rtl/mac_accumulator.sv
`default_nettype none
// =============================================================================
// mac_accumulator : aligns multiplier products to issued beats, sums each
//                   dot-product run and queues run results.   Rev 1.0
// =============================================================================
module mac_accumulator #(
  parameter int PROD_W    = 16,
  parameter int ACC_W     = 24,
  parameter int MULT_LAT  = 5,
  parameter int RES_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  mac_accumulator_if.slave bus
);
  localparam int c_PTR_W = $clog2(RES_DEPTH);
  localparam int c_CNT_W = $clog2(RES_DEPTH + 1);
  localparam int c_LST_W = $clog2(MULT_LAT + 1);
  localparam int c_OCC_W = $clog2(RES_DEPTH + MULT_LAT + 1);

  logic [MULT_LAT-1:0] r_vld;
  logic [MULT_LAT-1:0] r_lst;
  logic [ACC_W-1:0]    r_acc;
  logic                r_first;
  logic                r_run_ovf;
  logic [ACC_W-1:0]    r_mem_data [RES_DEPTH];
  logic                r_mem_ovf  [RES_DEPTH];
  logic [c_PTR_W-1:0]  r_wr_ptr;
  logic [c_PTR_W-1:0]  r_rd_ptr;
  logic [c_CNT_W-1:0]  r_count;

  logic                w_in_ready;
  logic                w_accept;
  logic                w_tail_vld;
  logic                w_tail_lst;
  logic                w_push;
  logic                w_pop;
  logic                w_out_valid;
  logic                w_sat;
  logic                w_ovf;
  logic [c_LST_W-1:0]  w_inflight_last;
  logic [c_OCC_W-1:0]  w_occupancy;
  logic [ACC_W-1:0]    w_base;
  logic [ACC_W:0]      w_sum_ext;
  logic [ACC_W-1:0]    w_sum;

  // Every last beat already issued owns a buffer slot, so a push can never find the buffer full.
  always_comb begin
    w_inflight_last = '0;
    for (int i = 0; i < MULT_LAT; i++) begin
      w_inflight_last = w_inflight_last + c_LST_W'(r_lst[i]);
    end
  end

  assign w_occupancy = c_OCC_W'(r_count) + c_OCC_W'(w_inflight_last);
  assign w_in_ready  = w_occupancy < c_OCC_W'(RES_DEPTH);
  assign w_accept    = bus.in_valid & w_in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      r_lst <= '0;
    end else begin
      r_vld <= {r_vld[MULT_LAT-2:0], w_accept};
      r_lst <= {r_lst[MULT_LAT-2:0], w_accept & bus.in_last};
    end
  end

  assign w_tail_vld = r_vld[MULT_LAT-1];
  assign w_tail_lst = r_lst[MULT_LAT-1];

  assign w_base    = r_first ? '0 : r_acc;
  assign w_sum_ext = {1'b0, w_base} + {{(ACC_W + 1 - PROD_W){1'b0}}, bus.product};
  assign w_sat     = w_sum_ext[ACC_W];
  assign w_sum     = w_sat ? '1 : w_sum_ext[ACC_W-1:0];
  assign w_ovf     = w_sat | (~r_first & r_run_ovf);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_first   <= 1'b1;
      r_run_ovf <= 1'b0;
    end else if (w_tail_vld) begin
      if (w_tail_lst) begin
        r_acc     <= '0;
        r_first   <= 1'b1;
        r_run_ovf <= 1'b0;
      end else begin
        r_acc     <= w_sum;
        r_first   <= 1'b0;
        r_run_ovf <= w_ovf;
      end
    end
  end

  assign w_push      = w_tail_vld & w_tail_lst;
  assign w_out_valid = (r_count != '0);
  assign w_pop       = w_out_valid & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry contents need no reset: they are masked whenever the buffer is empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= w_sum;
      r_mem_ovf[r_wr_ptr]  <= w_ovf;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = w_out_valid ? r_mem_data[r_rd_ptr] : '0;
  assign bus.out_ovf   = w_out_valid & r_mem_ovf[r_rd_ptr];
  assign bus.busy      = (|r_vld) | ~r_first | w_out_valid;
endmodule
`default_nettype wire

// File: tb/tb_mac_accumulator.sv
`default_nettype none
// =============================================================================
// tb_mac_accumulator : directed vector tables plus random runs against a
//                      run-level reference model.   Rev 1.0
// =============================================================================
module tb_mac_accumulator;
  localparam int PROD_W    = 16;
  localparam int ACC_W     = 24;
  localparam int MULT_LAT  = 5;
  localparam int RES_DEPTH = 2;
  localparam longint c_MAX = (longint'(1) << ACC_W) - 1;

  typedef struct {
    logic [ACC_W-1:0] data;
    logic             ovf;
    int               rdy;
  } res_t;

  typedef struct {
    logic [15:0]      a;
    logic [15:0]      b;
    logic [ACC_W-1:0] exp_data;
    logic             exp_ovf;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] op_a;
  logic [15:0] op_b;

  always #5 clk = ~clk;

  mac_accumulator_if #(.PROD_W(PROD_W), .ACC_W(ACC_W)) bus ();

  mac_accumulator #(
    .PROD_W(PROD_W), .ACC_W(ACC_W), .MULT_LAT(MULT_LAT), .RES_DEPTH(RES_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  // Upstream pip_multiplier stand-in: free-running, it multiplies whatever sits on the operands.
  logic [PROD_W-1:0] mpipe [MULT_LAT];
  always_ff @(posedge clk) begin
    mpipe[0] <= op_a * op_b;
    for (int i = 1; i < MULT_LAT; i++) mpipe[i] <= mpipe[i-1];
  end
  assign bus.product = mpipe[MULT_LAT-1];

  res_t             exp_q[$];
  longint           run_sum;
  int               run_beats;
  logic [ACC_W-1:0] got_q[$];
  logic             got_ovf_q[$];
  int               checks = 0;
  int               failures = 0;
  int               cyc = 0;
  int               last_acc_cyc = 0;
  bit               dut_acc;
  bit               rand_ready = 1'b0;
  vec_t             tbl2[4];
  vec_t             tbl3[3];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s cyc=%0d timed out", name, cyc);
  endtask

  // Reference model at run granularity: results appear MULT_LAT+1 cycles after the last beat.
  task automatic monitor();
    bit   exp_rdy, exp_ov, exp_busy;
    res_t r;
    logic [PROD_W-1:0] p;
    if (!rst_n) begin
      chk("rst_out_valid", longint'(bus.out_valid), 0);
      chk("rst_in_ready", longint'(bus.in_ready), 1);
      chk("rst_busy", longint'(bus.busy), 0);
      chk("rst_out_data", longint'(bus.out_data), 0);
      chk("rst_out_ovf", longint'(bus.out_ovf), 0);
      exp_q.delete();
      run_sum = 0;
      run_beats = 0;
      dut_acc = 1'b0;
      return;
    end
    exp_rdy  = exp_q.size() < RES_DEPTH;
    exp_ov   = (exp_q.size() != 0) && (exp_q[0].rdy <= cyc);
    exp_busy = (run_beats != 0) || (exp_q.size() != 0);
    chk("in_ready", longint'(bus.in_ready), longint'(exp_rdy));
    chk("out_valid", longint'(bus.out_valid), longint'(exp_ov));
    chk("busy", longint'(bus.busy), longint'(exp_busy));
    if (exp_ov) begin
      chk("out_data", longint'(bus.out_data), longint'(exp_q[0].data));
      chk("out_ovf", longint'(bus.out_ovf), longint'(exp_q[0].ovf));
    end else begin
      chk("empty_data", longint'(bus.out_data), 0);
      chk("empty_ovf", longint'(bus.out_ovf), 0);
    end
    if (bus.out_valid && bus.out_ready) begin
      got_q.push_back(bus.out_data);
      got_ovf_q.push_back(bus.out_ovf);
    end
    if (exp_ov && bus.out_ready) void'(exp_q.pop_front());
    dut_acc = bus.in_valid && bus.in_ready;
    if (bus.in_valid && exp_rdy) begin
      p = op_a * op_b;
      run_sum += longint'(p);
      run_beats++;
      if (bus.in_last) begin
        r.ovf  = run_sum > c_MAX;
        r.data = r.ovf ? '1 : ACC_W'(run_sum);
        r.rdy  = cyc + MULT_LAT + 1;
        exp_q.push_back(r);
        run_sum = 0;
        run_beats = 0;
        last_acc_cyc = cyc;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    cyc++;
    #1;
    if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic beat(input logic [15:0] a, input logic [15:0] b, input logic last);
    int n = 0;
    op_a = a;
    op_b = b;
    bus.in_valid = 1'b1;
    bus.in_last  = last;
    do begin
      tick();
      n++;
    end while (!dut_acc && n < 300);
    if (!dut_acc) fail("beat_accept");
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      op_a = 16'($urandom_range(1, 255));
      op_b = 16'($urandom_range(1, 255));
      tick();
    end
  endtask

  task automatic drain();
    int n = 0;
    bus.out_ready = 1'b1;
    while ((exp_q.size() != 0 || run_beats != 0) && n < 500) begin
      tick();
      n++;
    end
    if (n >= 500) fail("drain");
    repeat (2) tick();
  endtask

  task automatic check_got(input string name, input int idx, input logic [ACC_W-1:0] d, input logic o);
    if (idx < got_q.size()) begin
      chk({name, "_data"}, longint'(got_q[idx]), longint'(d));
      chk({name, "_ovf"}, longint'(got_ovf_q[idx]), longint'(o));
    end else begin
      fail({name, "_missing"});
    end
  endtask

  initial begin
    tbl2 = '{'{16'd13, 16'd7, 24'd91, 1'b0}, '{16'd255, 16'd255, 24'd65025, 1'b0},
             '{16'd0, 16'h123, 24'd0, 1'b0}, '{16'd128, 16'd2, 24'd256, 1'b0}};
    tbl3 = '{'{16'd13, 16'd7, 24'd91, 1'b0}, '{16'd255, 16'd255, 24'd65025, 1'b0},
             '{16'd4, 16'd5, 24'd20, 1'b0}};
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    op_a = '0;
    op_b = '0;
    run_sum = 0;
    run_beats = 0;
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // 1) four-beat run and result latency
    got_q.delete(); got_ovf_q.delete();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) beat(tbl2[i].a, tbl2[i].b, i == 3);
    while (cyc < last_acc_cyc + MULT_LAT) tick();
    chk("t1_valid_early", longint'(bus.out_valid), 0);
    tick();
    chk("t1_valid_on_time", longint'(bus.out_valid), 1);
    drain();
    chk("t1_count", got_q.size(), 1);
    check_got("t1", 0, 24'd65372, 1'b0);

    // 2) single-beat runs back to back
    got_q.delete(); got_ovf_q.delete();
    for (int i = 0; i < 4; i++) beat(tbl2[i].a, tbl2[i].b, 1'b1);
    drain();
    chk("t2_count", got_q.size(), 4);
    for (int i = 0; i < 4; i++) check_got("t2", i, tbl2[i].exp_data, tbl2[i].exp_ovf);

    // 3) consumer stalled: third run must be held off
    got_q.delete(); got_ovf_q.delete();
    bus.out_ready = 1'b0;
    beat(tbl3[0].a, tbl3[0].b, 1'b1);
    beat(tbl3[1].a, tbl3[1].b, 1'b1);
    op_a = tbl3[2].a;
    op_b = tbl3[2].b;
    bus.in_valid = 1'b1;
    bus.in_last  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t3_held", longint'(dut_acc), 0);
    end
    chk("t3_in_ready_low", longint'(bus.in_ready), 0);
    bus.out_ready = 1'b1;
    begin
      int n = 0;
      do begin tick(); n++; end while (!dut_acc && n < 50);
      if (!dut_acc) fail("t3_release");
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    drain();
    chk("t3_count", got_q.size(), 3);
    for (int i = 0; i < 3; i++) check_got("t3", i, tbl3[i].exp_data, tbl3[i].exp_ovf);

    // 4) saturation, then a clean run
    got_q.delete(); got_ovf_q.delete();
    for (int i = 0; i < 300; i++) beat(16'd255, 16'd255, i == 299);
    beat(16'd2, 16'd3, 1'b1);
    drain();
    chk("t4_count", got_q.size(), 2);
    check_got("t4_sat", 0, 24'hFFFFFF, 1'b1);
    check_got("t4_next", 1, 24'd6, 1'b0);

    // 5) bubbles with live operands
    got_q.delete(); got_ovf_q.delete();
    beat(16'd10, 16'd10, 1'b0);
    idle(3);
    beat(16'd20, 16'd20, 1'b1);
    drain();
    chk("t5_count", got_q.size(), 1);
    check_got("t5", 0, 24'd500, 1'b0);

    // 6) reset mid-run with a result buffered
    bus.out_ready = 1'b0;
    beat(16'd7, 16'd7, 1'b1);
    begin
      int n = 0;
      while (!bus.out_valid && n < 50) begin tick(); n++; end
      if (!bus.out_valid) fail("t6_buffered");
    end
    beat(16'd5, 16'd5, 1'b0);
    beat(16'd6, 16'd6, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("t6_valid_drop", longint'(bus.out_valid), 0);
    chk("t6_busy_drop", longint'(bus.busy), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    got_q.delete(); got_ovf_q.delete();
    bus.out_ready = 1'b1;
    beat(16'd3, 16'd3, 1'b1);
    drain();
    repeat (20) tick();
    chk("t6_count", got_q.size(), 1);
    check_got("t6", 0, 24'd9, 1'b0);

    // random runs, bubbles and consumer stalls
    rand_ready = 1'b1;
    for (int r = 0; r < 40; r++) begin
      int nb;
      nb = $urandom_range(1, 6);
      for (int k = 0; k < nb; k++) begin
        idle($urandom_range(0, 2));
        beat(16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)), k == nb - 1);
      end
    end
    rand_ready = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "simulation time limit");
  end
endmodule
`default_nettype wire
